// File: rtl/irm_fifo_receiver.sv
// rtl/irm_fifo_receiver.sv - NEC IR frame decoder with decoded-frame FIFO and register port
module irm_fifo_receiver #(
  parameter int UNIT_CYCLES = 28125,
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ir,
  input  logic        s_cs_n,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);
  localparam int DW = $clog2(24 * UNIT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [DW-1:0] U2  = DW'(2 * UNIT_CYCLES);
  localparam logic [DW-1:0] U3  = DW'(3 * UNIT_CYCLES);
  localparam logic [DW-1:0] U4  = DW'(4 * UNIT_CYCLES);
  localparam logic [DW-1:0] U6  = DW'(6 * UNIT_CYCLES);
  localparam logic [DW-1:0] U10 = DW'(10 * UNIT_CYCLES);
  localparam logic [DW-1:0] U12 = DW'(12 * UNIT_CYCLES);
  localparam logic [DW-1:0] U20 = DW'(20 * UNIT_CYCLES);
  localparam logic [DW-1:0] U24 = DW'(24 * UNIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, DONE, REP_MARK
  } state_t;

  logic [1:0]        sync;
  logic              lvl;
  logic [FW-1:0]     fcnt;
  logic              flip, fall, rise;
  logic [DW-1:0]     dur;
  state_t            state;
  logic [31:0]       shreg, last_code, push_data;
  logic              last_valid, push, rep_flag, ovf;
  logic [4:0]        bit_idx;
  logic [7:0]        errcnt;
  logic [2:0]        ctrl;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              wr_en, rd_en, clr_stat, full, nempty, pop, push_ok;
  logic              unused_wdata;

  assign flip     = (sync[1] != lvl) && (fcnt == FW'(FILTER_LEN - 1));
  assign fall     = flip && !sync[1];
  assign rise     = flip && sync[1];
  assign wr_en    = s_write && !s_cs_n;
  assign rd_en    = s_read && !s_cs_n;
  assign clr_stat = wr_en && (s_address == 2'd1);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign nempty   = (count != '0);
  assign pop      = rd_en && (s_address == 2'd0) && nempty;
  assign push_ok  = push && (!full || pop);
  assign unused_wdata = ^s_writedata[31:3];

  // Two-flop synchroniser followed by a run-length glitch filter on the IR level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= 2'b11;
      lvl  <= 1'b1;
      fcnt <= '0;
    end else begin
      sync <= {sync[0], ir};
      if (sync[1] == lvl) begin
        fcnt <= '0;
      end else if (flip) begin
        lvl  <= sync[1];
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  // Length of the current filtered level, restarted on every edge, saturating at 24 units
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dur <= '0;
    end else if (flip) begin
      dur <= '0;
    end else if (dur != U24) begin
      dur <= dur + DW'(1);
    end
  end

  // Frame decoder: classifies each finished mark/space and emits one push per accepted frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      last_code  <= '0;
      last_valid <= 1'b0;
      push       <= 1'b0;
      push_data  <= '0;
      errcnt     <= '0;
      rep_flag   <= 1'b0;
    end else begin
      push <= 1'b0;
      if (clr_stat && s_writedata[0]) errcnt <= '0;
      if (clr_stat && s_writedata[2]) rep_flag <= 1'b0;
      if (state != IDLE && state != DONE && dur > U20) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:       if (fall) state <= LEAD_MARK;
          LEAD_MARK:  if (rise) state <= (dur >= U12 && dur <= U20) ? LEAD_SPACE : IDLE;
          LEAD_SPACE: if (fall) begin
            if (dur >= U6 && dur <= U10) begin
              state   <= BIT_MARK;
              bit_idx <= '0;
            end else if (dur >= U3 && dur < U6) begin
              state <= REP_MARK;
            end else begin
              state <= IDLE;
            end
          end
          BIT_MARK:   if (rise) state <= (dur > U2) ? IDLE : BIT_SPACE;
          BIT_SPACE:  if (fall) begin
            if (dur > U4) begin
              state <= IDLE;
            end else begin
              shreg   <= {(dur >= U2), shreg[31:1]};
              bit_idx <= bit_idx + 5'd1;
              state   <= (bit_idx == 5'd31) ? DONE : BIT_MARK;
            end
          end
          DONE: begin
            if (ctrl[1] && (shreg[23:16] != ~shreg[31:24])) begin
              if (errcnt != 8'hFF) errcnt <= errcnt + 8'd1;
            end else begin
              push       <= 1'b1;
              push_data  <= shreg;
              last_code  <= shreg;
              last_valid <= 1'b1;
            end
            state <= IDLE;
          end
          REP_MARK:   if (rise) begin
            if (dur <= U2 && ctrl[2] && last_valid) begin
              push      <= 1'b1;
              push_data <= last_code;
              rep_flag  <= 1'b1;
            end
            state <= IDLE;
          end
          default:    state <= IDLE;
        endcase
      end
    end
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, occupancy, overflow flag, control register and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      ctrl   <= 3'b110;
      irq    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (clr_stat && s_writedata[1]) ovf <= 1'b0;
      if (push && full && !pop) ovf <= 1'b1;
      if (wr_en && s_address == 2'd2) ctrl <= s_writedata[2:0];
      irq <= ctrl[0] && (nempty || ovf);
    end
  end

  // Register read mux, driven only while a read is selected
  always_comb begin
    s_readdata = '0;
    if (rd_en) begin
      case (s_address)
        2'd0:    s_readdata = nempty ? mem[rd_ptr] : 32'h0;
        2'd1:    s_readdata = {errcnt, 8'(count), 13'b0, rep_flag, ovf, nempty};
        2'd2:    s_readdata = {29'b0, ctrl};
        default: s_readdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_irm_fifo_receiver.sv
// tb/tb_irm_fifo_receiver.sv - randomized NEC frame bench checked against a queue model
module tb_irm_fifo_receiver;
  localparam int U    = 10;
  localparam int D    = 4;
  localparam int FL   = 4;
  localparam int TAIL = 60;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ir = 1'b1;
  logic        s_cs_n = 1'b1;
  logic [1:0]  s_address = 2'd0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = 32'h0;
  logic [31:0] s_readdata;
  logic        irq;

  irm_fifo_receiver #(.UNIT_CYCLES(U), .FIFO_DEPTH(D), .FILTER_LEN(FL)) dut (
    .clk(clk), .reset_n(reset_n), .ir(ir), .s_cs_n(s_cs_n), .s_address(s_address),
    .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] mq[$];
  logic [7:0]  m_err;
  logic        m_ovf, m_rep, m_last_v;
  logic [31:0] m_last;
  logic [2:0]  m_ctrl;
  bit          model_valid = 1'b0;
  logic        exp_irq_d = 1'b0;
  int          push_k = -1;
  logic [31:0] oc[D+1];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_err = 8'd0; m_ovf = 1'b0; m_rep = 1'b0; m_last_v = 1'b0; m_last = 32'h0; m_ctrl = 3'b110;
  endfunction

  function automatic void model_push(input logic [31:0] c);
    if (mq.size() < D) mq.push_back(c);
    else m_ovf = 1'b1;
  endfunction

  function automatic void model_frame(input logic [31:0] c);
    if (m_ctrl[1] && (c[23:16] != ~c[31:24])) begin
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end else begin
      model_push(c);
      m_last = c;
      m_last_v = 1'b1;
    end
  endfunction

  function automatic void model_repeat();
    if (m_ctrl[2] && m_last_v) begin
      model_push(m_last);
      m_rep = 1'b1;
    end
  endfunction

  function automatic logic [31:0] model_reg(input logic [1:0] a);
    case (a)
      2'd0:    return (mq.size() != 0) ? mq[0] : 32'h0;
      2'd1:    return {m_err, 8'(mq.size()), 13'b0, m_rep, m_ovf, (mq.size() != 0)};
      2'd2:    return {29'b0, m_ctrl};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] make_code(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  // irq is registered, so the expectation lags the model by one clock
  always @(posedge clk) exp_irq_d <= m_ctrl[0] & ((mq.size() != 0) | m_ovf);

  always @(negedge clk) begin
    if (model_valid) check("irq", {31'b0, irq}, {31'b0, exp_irq_d});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic lv, input int n);
    ir = lv;
    repeat (n) step();
  endtask

  task automatic do_reset();
    model_valid = 1'b0;
    reset_n = 1'b0;
    s_cs_n = 1'b1; s_read = 1'b0; s_write = 1'b0;
    model_reset();
    hold(1'b1, 3);
    reset_n = 1'b1;
    step(); step();
    model_valid = 1'b1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    s_cs_n = 1'b0; s_write = 1'b1; s_address = a; s_writedata = d;
    step();
    s_cs_n = 1'b1; s_write = 1'b0;
    if (a == 2'd1) begin
      if (d[0]) m_err = 8'd0;
      if (d[1]) m_ovf = 1'b0;
      if (d[2]) m_rep = 1'b0;
    end else if (a == 2'd2) begin
      m_ctrl = d[2:0];
    end
  endtask

  task automatic reg_access(input logic [1:0] a, input string name, input logic [31:0] e);
    logic [31:0] dropped;
    s_cs_n = 1'b0; s_read = 1'b1; s_address = a;
    #2;
    check(name, s_readdata, e);
    step();
    s_cs_n = 1'b1; s_read = 1'b0;
    if (a == 2'd0 && mq.size() != 0) dropped = mq.pop_front();
  endtask

  task automatic reg_check(input logic [1:0] a, input string name);
    reg_access(a, name, model_reg(a));
  endtask

  task automatic reg_lit(input logic [1:0] a, input string name, input logic [31:0] lit);
    reg_access(a, name, lit);
  endtask

  // tail_mode: 0 plain, 1 poll STATUS to find the push cycle, 2 pop DATA on that cycle
  task automatic send_frame(input logic [31:0] code, input bit glitch, input int cut,
                            input bit cut_reset, input int tail_mode);
    bit stop;
    int sp, a;
    logic [31:0] dropped;
    stop = 1'b0;
    model_valid = 1'b0;
    hold(1'b0, 16*U);
    hold(1'b1, 8*U);
    for (int i = 0; i < 32 && !stop; i++) begin
      if (i == cut) begin
        stop = 1'b1;
        if (cut_reset) hold(1'b0, U/2);
        else begin
          hold(1'b0, 25*U);
          hold(1'b1, 5*U);
        end
      end else begin
        hold(1'b0, U);
        sp = code[i] ? 3*U : U;
        if (glitch) begin
          a = sp/2 - 1;
          hold(1'b1, a);
          hold(1'b0, FL-1);
          hold(1'b1, sp - a - (FL-1));
        end else begin
          hold(1'b1, sp);
        end
      end
    end
    if (!stop) begin
      for (int j = 0; j < TAIL; j++) begin
        ir = (j < U) ? 1'b0 : 1'b1;
        if (tail_mode == 1) begin
          s_cs_n = 1'b0; s_read = 1'b1; s_address = 2'd1;
        end else if (tail_mode == 2) begin
          if (j == push_k - 1) begin
            s_cs_n = 1'b0; s_read = 1'b1; s_address = 2'd0;
          end else begin
            s_cs_n = 1'b1; s_read = 1'b0;
          end
        end
        #2;
        if (tail_mode == 1 && push_k < 0 && s_readdata[23:16] != 8'd0) push_k = j;
        if (tail_mode == 2 && j == push_k - 1) check("coincident_pop_head", s_readdata, mq[0]);
        step();
      end
      s_cs_n = 1'b1; s_read = 1'b0;
      if (tail_mode == 2 && push_k >= 1 && mq.size() != 0) dropped = mq.pop_front();
      model_frame(code);
    end
    if (!(stop && cut_reset)) begin
      step(); step();
      model_valid = 1'b1;
    end
  endtask

  task automatic send_repeat();
    model_valid = 1'b0;
    hold(1'b0, 16*U);
    hold(1'b1, 4*U);
    hold(1'b0, U);
    hold(1'b1, 50);
    model_repeat();
    step(); step();
    model_valid = 1'b1;
  endtask

  initial begin
    do_reset();
    reg_lit(2'd0, "reset_data", 32'h0);
    reg_lit(2'd1, "reset_status", 32'h0);
    reg_lit(2'd2, "reset_ctrl", 32'h6);
    reg_lit(2'd3, "reset_addr3", 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);

    send_frame(32'hBA45FF00, 1'b0, -1, 1'b0, 1);
    check("push_seen_in_tail", (push_k > 0) ? 32'h1 : 32'h0, 32'h1);
    reg_lit(2'd1, "status_one", 32'h00010001);
    reg_lit(2'd0, "data_nec", 32'hBA45FF00);
    reg_lit(2'd1, "status_empty", 32'h0);

    send_frame(32'hBB45FF00, 1'b0, -1, 1'b0, 0);
    reg_lit(2'd1, "status_errcnt", 32'h01000000);
    reg_write(2'd2, 32'h4);
    send_frame(32'hBB45FF00, 1'b0, -1, 1'b0, 0);
    reg_lit(2'd0, "data_nochk", 32'hBB45FF00);
    reg_write(2'd1, 32'h1);
    reg_write(2'd2, 32'h6);
    reg_check(2'd1, "status_after_clr");

    send_frame(32'hE51A7F80, 1'b0, -1, 1'b0, 0);
    send_repeat();
    reg_lit(2'd1, "status_rep", 32'h00020005);
    reg_lit(2'd0, "rep_first", 32'hE51A7F80);
    reg_lit(2'd0, "rep_second", 32'hE51A7F80);
    reg_write(2'd1, 32'h4);

    send_frame(32'h9D62BF40, 1'b0, 10, 1'b1, 0);
    do_reset();
    send_repeat();
    reg_lit(2'd1, "status_rep_after_reset", 32'h0);
    send_frame(32'h9D62BF40, 1'b0, -1, 1'b0, 0);
    reg_lit(2'd0, "data_after_reset", 32'h9D62BF40);

    send_frame(32'hF708FB04, 1'b1, -1, 1'b0, 0);
    reg_lit(2'd0, "data_glitched", 32'hF708FB04);
    send_frame(32'hF708FB04, 1'b0, 12, 1'b0, 0);
    reg_lit(2'd1, "status_after_abort", 32'h0);

    for (int r = 0; r < 12; r++) begin
      logic [7:0] ad, cm, cn;
      ad = 8'($urandom);
      cm = 8'($urandom);
      cn = ($urandom_range(0, 3) != 0) ? ~cm : 8'($urandom);
      if ($urandom_range(0, 2) == 0) reg_write(2'd2, {29'b0, 3'($urandom_range(0, 7))});
      send_frame({cn, cm, ~ad, ad}, 1'($urandom_range(0, 1)), -1, 1'b0, 0);
      if ($urandom_range(0, 3) == 0) send_repeat();
      repeat ($urandom_range(0, 2)) reg_check(2'd0, "rand_data");
      reg_check(2'd1, "rand_status");
    end
    while (mq.size() != 0) reg_check(2'd0, "rand_drain");
    reg_write(2'd1, 32'h7);
    reg_write(2'd2, 32'h7);
    reg_check(2'd1, "status_clean");

    for (int i = 0; i <= D; i++) begin
      oc[i] = make_code(8'(i + 1), 8'(16 * i + 3));
      send_frame(oc[i], 1'b0, -1, 1'b0, 0);
    end
    reg_lit(2'd1, "status_full_ovf", 32'h00040003);
    check("irq_full", {31'b0, irq}, 32'h1);
    reg_write(2'd1, 32'h2);
    for (int i = 0; i < D; i++) reg_lit(2'd0, "ovf_drain_order", oc[i]);
    step(); step();
    check("irq_drained", {31'b0, irq}, 32'h0);
    reg_lit(2'd1, "status_drained", 32'h0);

    for (int i = 0; i <= D; i++) oc[i] = make_code(8'(i + 40), 8'(7 * i + 9));
    for (int i = 0; i < D; i++) send_frame(oc[i], 1'b0, -1, 1'b0, 0);
    send_frame(oc[D], 1'b0, -1, 1'b0, 2);
    reg_lit(2'd1, "status_coincident", 32'h00040001);
    for (int i = 1; i <= D; i++) reg_lit(2'd0, "coincident_order", oc[i]);
    reg_lit(2'd1, "status_final", 32'h0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/irm_fifo_receiver.md
IRM_FIFO_RECEIVER -- requirements
Module: irm_fifo_receiver

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 28125, meaning clk cycles per 562.5 us NEC unit (50 MHz clock).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning decoded-frame FIFO entries; power of two, 2..256.
REQ-003 SHALL have parameter FILTER_LEN, default 4, meaning consecutive equal samples required to accept an ir level change.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  input  1  system clock; reset_n  input  1  async reset, active low.
REQ-005 SHALL have ports: ir  input  1  demodulated IR, idle high, burst low.
REQ-006 SHALL have ports: s_cs_n  input  1  slave select, active low; s_address  input  2  register index; s_read  input  1; s_write  input  1; s_writedata  input  32; s_readdata  output  32; irq  output  1  level interrupt.

Function
REQ-007 SHALL synchronise ir through two flops, then filter: filtered level changes only after FILTER_LEN equal synchronised samples.
REQ-008 SHALL measure each filtered low (mark) and high (space) duration with a counter saturating at 24*UNIT_CYCLES.
REQ-009 SHALL implement FSM IDLE -> LEAD_MARK -> LEAD_SPACE -> BIT_MARK -> BIT_SPACE -> (BIT_MARK | DONE), plus REP_MARK for repeat frames.
REQ-010 IDLE: falling edge -> LEAD_MARK; leader mark 12U..20U -> LEAD_SPACE, otherwise -> IDLE.
REQ-011 LEAD_SPACE: 6U..10U -> BIT_MARK with bit index 0; 3U..<6U -> REP_MARK; otherwise -> IDLE.
REQ-012 BIT_MARK: mark > 2U -> IDLE; BIT_SPACE: space < 2U is 0, 2U..4U is 1, > 4U -> IDLE (abort, no push).
REQ-013 Bits SHALL be shifted LSB-first into a 32-bit frame {cmd_n[31:24], cmd[23:16], addr_n[15:8], addr[7:0]}; after bit 31 -> DONE.
REQ-014 DONE: when CTRL.chk=1 and cmd != ~cmd_n, SHALL drop frame and increment ERRCNT (8-bit, saturating at 255); else push frame and store as last_code; return to IDLE in one cycle.
REQ-015 REP_MARK: trailing mark <= 2U with CTRL.rep=1 and last_code valid SHALL push last_code and set STATUS.rep sticky; else no push.
REQ-016 Any level lasting > 20U outside IDLE SHALL abort to IDLE, discarding the partial frame.
REQ-017 Register map (read data combinational on s_address, valid while s_read & ~s_cs_n): 0 DATA = FIFO head (0 when empty); 1 STATUS = {ERRCNT[31:24], count[23:16], 13'b0, rep[2], ovf[1], nempty[0]}; 2 CTRL = {29'b0, rep[2], chk[1], ien[0]}; 3 reads 0.
REQ-018 Read of address 0 SHALL pop one entry at that clock edge; a read with FIFO empty SHALL have no effect.
REQ-019 Push with FIFO full and no simultaneous pop SHALL drop the new frame and set ovf; simultaneous push and pop when full SHALL both succeed, count unchanged.
REQ-020 Write to address 1 SHALL clear ovf/rep/ERRCNT where the corresponding writedata bit is 1 (bit 0 clears ERRCNT); write to address 2 SHALL load CTRL; writes to 0 and 3 SHALL be ignored.
REQ-021 irq SHALL be registered: irq = ien & (nempty | ovf), updating one cycle after the cause changes.
REQ-022 Decoder SHALL run regardless of ien; FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-023 On reset_n low, asynchronously: FSM IDLE, FIFO empty, count 0, ovf/rep 0, ERRCNT 0, last_code invalid, CTRL = 3'b110 (rep=1, chk=1, ien=0), irq 0, filtered ir 1.
REQ-024 Reset mid-frame SHALL discard the partial frame; the first frame after release decodes normally.

Verification
REQ-025 Valid NEC frame addr 0x00, cmd 0x45 -> one entry; DATA reads 0xBA45FF00; count 1 -> 0 after read.
REQ-026 Frame with cmd_n 0xBB, cmd 0x45, chk=1 -> no push, ERRCNT=1; with chk=0 -> push 0xBB45FF00.
REQ-027 Valid frame then repeat frame, rep=1 -> two identical entries, STATUS.rep=1; repeat after reset -> no push.
REQ-028 FIFO_DEPTH+1 frames without reads -> count=FIFO_DEPTH, ovf=1, entry FIFO_DEPTH+1 lost; ien=1 -> irq=1; write 0x2 to STATUS and drain -> irq=0.
REQ-029 Glitches of FILTER_LEN-1 cycles during bit spaces -> frame decodes unchanged; ir held low 25U mid-frame -> abort, no push.
REQ-030 Pop coincident with push at full -> count stays FIFO_DEPTH, ovf stays 0, order preserved.
